// File: rtl/fp_special_addsub_pipe.sv
// Zero/Inf/NaN special-case resolver for an FP add/sub, 2-stage valid/ready pipe.
// Optional FP_NAN_QUIET_EN: quiet propagated NaNs, flag signaling NaN inputs.
module fp_special_addsub_pipe #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   A,
  input  logic [EXP_W+MANT_W:0]   B,
  input  logic                    MODE,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   Q,
  output logic                    exc,
  output logic [4:0]              FLAGS,
  input  logic                    flag_clr,
  output logic [4:0]              FLAGS_STICKY
);

  localparam int W = 1 + EXP_W + MANT_W;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef struct packed {
    logic              a_s;
    logic              b_s;
    logic              sb;
    logic [EXP_W-1:0]  a_e;
    logic [EXP_W-1:0]  b_e;
    logic [MANT_W-1:0] a_m;
    logic [MANT_W-1:0] b_m;
    logic              a_z;
    logic              a_i;
    logic              a_n;
    logic              b_z;
    logic              b_i;
    logic              b_n;
`ifdef FP_NAN_QUIET_EN
    logic              a_sn;
    logic              b_sn;
`endif
  } s1_t;

  s1_t              cls, s1_d, s1_q;
  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic [W-1:0]     q_d, q_q;
  logic             exc_d, exc_q;
  logic [4:0]       flags_d, flags_q;
  logic [4:0]       sticky_d, sticky_q;
  logic             s2_adv;
  logic [W-1:0]     res_q;
  logic             res_exc;
  logic             res_inv;
  logic [MANT_W-1:0] min_m;

  assign s2_adv       = !s2_valid_q || out_ready;
  assign in_ready     = !s1_valid_q || s2_adv;
  assign out_valid    = s2_valid_q;
  assign Q            = q_q;
  assign exc          = exc_q;
  assign FLAGS        = flags_q;
  assign FLAGS_STICKY = sticky_q;

  always_comb begin
    cls     = '0;
    cls.a_s = A[W-1];
    cls.b_s = B[W-1];
    cls.sb  = B[W-1] ^ MODE;
    cls.a_e = A[W-2 -: EXP_W];
    cls.b_e = B[W-2 -: EXP_W];
    cls.a_m = A[MANT_W-1:0];
    cls.b_m = B[MANT_W-1:0];
    cls.a_z = (cls.a_e == '0) && (cls.a_m == '0);
    cls.b_z = (cls.b_e == '0) && (cls.b_m == '0);
    cls.a_i = (&cls.a_e) && (cls.a_m == '0);
    cls.b_i = (&cls.b_e) && (cls.b_m == '0);
    cls.a_n = (&cls.a_e) && (cls.a_m != '0);
    cls.b_n = (&cls.b_e) && (cls.b_m != '0);
`ifdef FP_NAN_QUIET_EN
    cls.a_sn = cls.a_n && !A[MANT_W-1];
    cls.b_sn = cls.b_n && !B[MANT_W-1];
`endif
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = cls;
    end
  end

  // Priority chain: earlier rows win when classes overlap.
  always_comb begin
    res_q   = '0;
    res_exc = 1'b1;
    res_inv = 1'b0;
    min_m   = (s1_q.a_m < s1_q.b_m) ? s1_q.a_m : s1_q.b_m;
    if (s1_q.a_n && s1_q.b_n) begin
      res_q = {s1_q.a_s, {EXP_W{1'b1}}, min_m};
    end else if (s1_q.a_i && s1_q.b_i && (s1_q.a_s != s1_q.sb)) begin
      res_q   = QNAN;
      res_inv = 1'b1;
    end else if (s1_q.a_n) begin
      res_q = {s1_q.a_s, s1_q.a_e, s1_q.a_m};
    end else if (s1_q.b_n) begin
      res_q = {s1_q.b_s, s1_q.b_e, s1_q.b_m};
    end else if (s1_q.a_i) begin
      res_q = {s1_q.a_s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (s1_q.b_i) begin
      res_q = {s1_q.sb, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (s1_q.a_z && s1_q.b_z) begin
      res_q = {s1_q.a_s & s1_q.sb, {(W-1){1'b0}}};
    end else if (s1_q.a_z) begin
      res_q = {s1_q.sb, s1_q.b_e, s1_q.b_m};
    end else if (s1_q.b_z) begin
      res_q = {s1_q.a_s, s1_q.a_e, s1_q.a_m};
    end else begin
      res_exc = 1'b0;
    end
`ifdef FP_NAN_QUIET_EN
    if (s1_q.a_n || s1_q.b_n) begin
      res_q[MANT_W-1] = 1'b1;
      res_inv         = s1_q.a_sn || s1_q.b_sn;
    end
`endif
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    q_d        = q_q;
    exc_d      = exc_q;
    flags_d    = flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      q_d        = s1_valid_q ? res_q : '0;
      exc_d      = s1_valid_q && res_exc;
      flags_d    = {s1_valid_q && res_inv, 4'b0000};
    end
    sticky_d = flag_clr ? 5'b00000 : sticky_q;
    if (s2_valid_q && out_ready) sticky_d = sticky_d | flags_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      q_q        <= '0;
      exc_q      <= 1'b0;
      flags_q    <= '0;
      sticky_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      q_q        <= q_d;
      exc_q      <= exc_d;
      flags_q    <= flags_d;
      sticky_q   <= sticky_d;
    end
    s1_q <= s1_d;
  end

endmodule
